// File: rtl/nto1_mbit_stream_mux_if.sv
// Bundle for the N-to-1 stream mux: per-channel inputs, force-select control and
// the single registered output stream.
interface nto1_mbit_stream_mux_if #(
  parameter int N = 16,
  parameter int M = 32
);
  localparam int SW = $clog2(N);

  logic [N*M-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           sel_force_en;
  logic [SW-1:0]  sel_force;
  logic [M-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_data, in_valid, sel_force_en, sel_force, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel_force_en, sel_force, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/nto1_mbit_stream_mux.sv
// N-to-1, M-bit streaming mux: round-robin or fixed-priority arbiter with a forced-select
// override, feeding a single registered output slot that sustains one beat per cycle.
module nto1_mbit_stream_mux #(
  parameter int N  = 16,
  parameter int M  = 32,
  parameter int RR = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  nto1_mbit_stream_mux_if.slave bus
);
  localparam int          SW = $clog2(N);
  localparam int unsigned NU = N;

  logic [SW-1:0] rr_ptr;
  logic [M-1:0]  out_data_q;
  logic [SW-1:0] out_sel_q;
  logic          out_valid_q;

  logic          load_ok;
  logic          gnt_any;
  logic [SW-1:0] gnt_idx;
  logic [N-1:0]  grant;
  logic [M-1:0]  sel_data;
  logic          xfer;

  assign load_ok = ~out_valid_q | bus.out_ready;

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    if (bus.sel_force_en) begin
      // Loop compare keeps out-of-range sel_force values from ever matching a channel.
      for (int unsigned i = 0; i < NU; i++) begin
        if (bus.sel_force == SW'(i) && bus.in_valid[i]) begin
          gnt_any  = 1'b1;
          gnt_idx  = SW'(i);
          grant[i] = 1'b1;
        end
      end
    end else if (RR != 0) begin
      for (int unsigned k = 0; k < NU; k++) begin
        idx = 32'(rr_ptr) + k;
        if (idx >= NU) idx = idx - NU;
        if (!gnt_any && bus.in_valid[idx]) begin
          gnt_any    = 1'b1;
          gnt_idx    = SW'(idx);
          grant[idx] = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < NU; k++) begin
        if (!gnt_any && bus.in_valid[k]) begin
          gnt_any  = 1'b1;
          gnt_idx  = SW'(k);
          grant[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (grant[i]) sel_data = bus.in_data[i*M +: M];
    end
  end

  assign xfer         = gnt_any & load_ok & rst_n;
  assign bus.in_ready = grant & {N{load_ok & rst_n}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr      <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_sel_q   <= gnt_idx;
      if (RR != 0 && !bus.sel_force_en)
        rr_ptr <= (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
endmodule
